// File: rtl/fe_pkg.sv
// Shared field-element definitions for the 2^255-19 arithmetic layer.
package fe_pkg;
  localparam int FE_W = 256;
  typedef logic [FE_W-1:0] fe_t;
  localparam fe_t P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef enum logic [2:0] {IDLE, RED0, RED1, INIT, ITER, DONE} inv_state_e;
endpackage

// File: rtl/mod_p_addsub.sv
// Combinational helpers for the inverter's coefficient registers:
// modular difference and modular halving, both for operands already in [0,M).
module mod_p_addsub import fe_pkg::*; #(
  parameter int W = FE_W + 1,
  parameter logic [W-1:0] M = W'(P)
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic [W-1:0] half
);

  assign diff = (x >= y) ? (x - y) : (x - y + M);

  // For odd x (and odd M), (x+M)/2 == floor(x/2) + floor(M/2) + 1 without a wider adder.
  assign half = (x >> 1) + (x[0] ? ((M >> 1) + W'(1)) : '0);

endmodule

// File: rtl/mod_inv_p.sv
// Sequential modular inverter mod 2^255-19 using the binary extended Euclidean
// algorithm, one datapath step per clock.
module mod_inv_p #(
  parameter int N = fe_pkg::FE_W,
  parameter logic [N-1:0] P = N'(fe_pkg::P)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] inv,
  output logic         err
);
  import fe_pkg::*;

  inv_state_e   state;
  logic [N-1:0] u, v;
  logic [N:0]   x1, x2;
  logic [N:0]   x1_minus_x2, x2_minus_x1, x1_half, x2_half;

  mod_p_addsub #(.W(N+1), .M({1'b0, P})) u_x1_path (
    .x(x1), .y(x2), .diff(x1_minus_x2), .half(x1_half)
  );

  mod_p_addsub #(.W(N+1), .M({1'b0, P})) u_x2_path (
    .x(x2), .y(x1), .diff(x2_minus_x1), .half(x2_half)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      inv   <= '0;
      err   <= 1'b0;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            u     <= a;
            inv   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= RED0;
          end
        end
        RED0: begin
          if (u >= P) u <= u - P;
          state <= RED1;
        end
        RED1: begin
          if (u >= P) u <= u - P;
          state <= INIT;
        end
        INIT: begin
          if (u == '0) begin
            err   <= 1'b1;
            inv   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            v     <= P;
            x1    <= (N+1)'(1);
            x2    <= '0;
            state <= ITER;
          end
        end
        // Exactly one reduction per cycle; the coefficient paths keep x1, x2 in [0,P).
        ITER: begin
          if (u == N'(1)) begin
            inv   <= x1[N-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (v == N'(1)) begin
            inv   <= x2[N-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_minus_x2;
          end else begin
            v  <= v - u;
            x2 <= x2_minus_x1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
